// File: rtl/ervp_tl2axi_request_scheduler.sv
// ervp_tl2axi_request_scheduler
//   Purpose : turns single-beat TileLink-UL A requests into AXI AR or AW+W
//             transactions and queues a response record per transaction for
//             the response converter.
//   Latency : A handshake in cycle N -> awvalid/arvalid and *_info_valid in
//             cycle N+1; one request per 2 cycles at best.
//   Backpressure: a_ready is low while a transaction is in flight or while
//             the target record FIFO is full; AXI valids hold until ready.
//   Ports   : clk/rst; TileLink A (a_*); AXI AW/W/AR masters; wr_info_* and
//             rd_info_* record FIFO heads with pop strobes.
//   Config  : `define TL2AXI_SCHED_EARLY_W_EN raises wvalid together with
//             awvalid; otherwise W waits for the AW handshake.

// Small record FIFO. Pop on empty is dropped; push is never issued when full
// because the scheduler gates a_ready on the full flag.
module ervp_tl2axi_request_scheduler_info_fifo #(
  parameter int BW_REC = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BW_REC-1:0] push_rec,
  input  logic              pop,
  output logic              valid,
  output logic              full,
  output logic [BW_REC-1:0] head
);
  localparam int BW_PTR = $clog2(DEPTH);
  localparam int BW_CNT = BW_PTR + 1;

  logic [BW_REC-1:0] mem [DEPTH];
  logic [BW_PTR-1:0] wr_ptr;
  logic [BW_PTR-1:0] rd_ptr;
  logic [BW_CNT-1:0] cnt;
  logic              do_pop;

  assign do_pop = pop && (cnt != '0);
  assign valid  = (cnt != '0);
  assign full   = (cnt == BW_CNT'(DEPTH));
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push)   wr_ptr <= wr_ptr + BW_PTR'(1);
      if (do_pop) rd_ptr <= rd_ptr + BW_PTR'(1);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + BW_CNT'(1);
        2'b01:   cnt <= cnt - BW_CNT'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end
endmodule

module ervp_tl2axi_request_scheduler #(
  parameter int BW_ADDR         = 32,
  parameter int BW_DATA         = 32,
  parameter int BW_SIZE         = 3,
  parameter int BW_SOURCE       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              a_valid,
  output logic                              a_ready,
  input  logic [2:0]                        a_opcode,
  input  logic [BW_SIZE-1:0]                a_size,
  input  logic [BW_SOURCE-1:0]              a_source,
  input  logic [BW_ADDR-1:0]                a_address,
  input  logic [BW_DATA/8-1:0]              a_mask,
  input  logic [BW_DATA-1:0]                a_data,
  output logic                              awvalid,
  input  logic                              awready,
  output logic [BW_ADDR-1:0]                awaddr,
  output logic [7:0]                        awlen,
  output logic [2:0]                        awsize,
  output logic [1:0]                        awburst,
  output logic                              wvalid,
  input  logic                              wready,
  output logic [BW_DATA-1:0]                wdata,
  output logic [BW_DATA/8-1:0]              wstrb,
  output logic                              wlast,
  output logic                              arvalid,
  input  logic                              arready,
  output logic [BW_ADDR-1:0]                araddr,
  output logic [7:0]                        arlen,
  output logic [2:0]                        arsize,
  output logic [1:0]                        arburst,
  output logic                              wr_info_valid,
  output logic [3+BW_SIZE+BW_SOURCE+1-1:0]  wr_info,
  input  logic                              wr_info_pop,
  output logic                              rd_info_valid,
  output logic [3+BW_SIZE+BW_SOURCE+1-1:0]  rd_info,
  input  logic                              rd_info_pop
);
  localparam int BW_STRB = BW_DATA / 8;
  localparam int BW_INFO = 3 + BW_SIZE + BW_SOURCE + 1;

`ifdef TL2AXI_SCHED_EARLY_W_EN
  localparam logic EARLY_W = 1'b1;
`else
  localparam logic EARLY_W = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t               state;
  logic [BW_ADDR-1:0]   addr_q;
  logic [BW_SIZE-1:0]   size_q;
  logic [BW_STRB-1:0]   mask_q;
  logic [BW_DATA-1:0]   data_q;
  logic                 aw_done;
  logic                 w_done;

  logic                 is_write_req;
  logic                 wr_full;
  logic                 rd_full;
  logic                 a_fire;
  logic                 aw_fire;
  logic                 w_fire;
  logic                 ar_fire;
  logic [2:0]           rec_opcode;
  logic                 rec_denied;
  logic [BW_INFO-1:0]   new_rec;

  // PutFull (0) and PutPartial (1) are writes; everything else goes out as a
  // read, with unsupported opcodes flagged as denied in the record.
  assign is_write_req = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign rec_opcode   = is_write_req ? 3'd0 : 3'd1;
  assign rec_denied   = !is_write_req && (a_opcode != 3'd4);
  assign new_rec      = {rec_opcode, a_size, a_source, rec_denied};

  // rst gates a_ready directly so it is low for the whole reset pulse.
  assign a_ready = !rst && (state == IDLE) && (is_write_req ? !wr_full : !rd_full);
  assign a_fire  = a_valid && a_ready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;

  ervp_tl2axi_request_scheduler_info_fifo #(
    .BW_REC (BW_INFO),
    .DEPTH  (MAX_OUTSTANDING)
  ) u_wr_info (
    .clk      (clk),
    .rst      (rst),
    .push     (a_fire && is_write_req),
    .push_rec (new_rec),
    .pop      (wr_info_pop),
    .valid    (wr_info_valid),
    .full     (wr_full),
    .head     (wr_info)
  );

  ervp_tl2axi_request_scheduler_info_fifo #(
    .BW_REC (BW_INFO),
    .DEPTH  (MAX_OUTSTANDING)
  ) u_rd_info (
    .clk      (clk),
    .rst      (rst),
    .push     (a_fire && !is_write_req),
    .push_rec (new_rec),
    .pop      (rd_info_pop),
    .valid    (rd_info_valid),
    .full     (rd_full),
    .head     (rd_info)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_fire) begin
            addr_q <= a_address;
            size_q <= a_size;
            mask_q <= a_mask;
            data_q <= a_data;
            if (is_write_req) begin
              state   <= WRITE;
              awvalid <= 1'b1;
              wvalid  <= EARLY_W;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= READ;
              arvalid <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
            // Late-W mode: W is released only once the slave has taken AW.
            if (!EARLY_W) wvalid <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // Leave as soon as the last of the two handshakes lands, which
          // can be both in the same cycle.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        READ: begin
          if (ar_fire) begin
            arvalid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'(size_q);
  assign awburst = 2'b01;
  assign wdata   = data_q;
  assign wstrb   = mask_q;
  assign wlast   = 1'b1;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'(size_q);
  assign arburst = 2'b01;
endmodule

// File: tb/tb_ervp_tl2axi_request_scheduler.sv
module tb_ervp_tl2axi_request_scheduler;
  localparam int BW_ADDR = 32;
  localparam int BW_DATA = 32;
  localparam int BW_SIZE = 3;
  localparam int BW_SOURCE = 4;
  localparam int MAXO = 4;
  localparam int BW_STRB = BW_DATA / 8;
  localparam int BW_INFO = 3 + BW_SIZE + BW_SOURCE + 1;

`ifdef TL2AXI_SCHED_EARLY_W_EN
  localparam logic EARLY_W = 1'b1;
`else
  localparam logic EARLY_W = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic a_valid, a_ready;
  logic [2:0] a_opcode;
  logic [BW_SIZE-1:0] a_size;
  logic [BW_SOURCE-1:0] a_source;
  logic [BW_ADDR-1:0] a_address;
  logic [BW_STRB-1:0] a_mask;
  logic [BW_DATA-1:0] a_data;
  logic awvalid, awready, wvalid, wready, wlast, arvalid, arready;
  logic [BW_ADDR-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst;
  logic [BW_DATA-1:0] wdata;
  logic [BW_STRB-1:0] wstrb;
  logic wr_info_valid, rd_info_valid, wr_info_pop, rd_info_pop;
  logic [BW_INFO-1:0] wr_info, rd_info;

  ervp_tl2axi_request_scheduler #(
    .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_SIZE(BW_SIZE),
    .BW_SOURCE(BW_SOURCE), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .wr_info_valid(wr_info_valid), .wr_info(wr_info), .wr_info_pop(wr_info_pop),
    .rd_info_valid(rd_info_valid), .rd_info(rd_info), .rd_info_pop(rd_info_pop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected/not seen at %0t", name, $time);
  endtask

  // Reference model: expected AXI transactions and records in issue order,
  // plus which AXI handshakes of the current transaction are still owed.
  logic [BW_ADDR+2:0]         exp_ar[$];
  logic [BW_ADDR+2:0]         exp_aw[$];
  logic [BW_DATA+BW_STRB-1:0] exp_w[$];
  logic [BW_INFO-1:0]         exp_wr[$];
  logic [BW_INFO-1:0]         exp_rd[$];
  bit ar_pend = 0, aw_pend = 0, w_pend = 0;
  logic [BW_ADDR+2:0]         e_a;
  logic [BW_DATA+BW_STRB-1:0] e_w;
  bit tgt_wr, exp_rdy;

  always @(negedge clk) begin
    if (!rst) begin
      tgt_wr  = (a_opcode == 3'd0) || (a_opcode == 3'd1);
      exp_rdy = !(ar_pend || aw_pend || w_pend) &&
                (tgt_wr ? (exp_wr.size() < MAXO) : (exp_rd.size() < MAXO));
      chk("a_ready", 64'(a_ready), 64'(exp_rdy));
      chk("awvalid", 64'(awvalid), 64'(aw_pend));
      chk("arvalid", 64'(arvalid), 64'(ar_pend));
      chk("wvalid", 64'(wvalid), 64'(w_pend && (EARLY_W || !aw_pend)));
      chk("wr_info_valid", 64'(wr_info_valid), 64'(exp_wr.size() != 0));
      chk("rd_info_valid", 64'(rd_info_valid), 64'(exp_rd.size() != 0));
      if (wr_info_valid && exp_wr.size() != 0) chk("wr_info", 64'(wr_info), 64'(exp_wr[0]));
      if (rd_info_valid && exp_rd.size() != 0) chk("rd_info", 64'(rd_info), 64'(exp_rd[0]));

      if (arvalid && arready) begin
        if (exp_ar.size() == 0) fail_now("ar_unexpected");
        else begin
          e_a = exp_ar.pop_front();
          chk("araddr", 64'(araddr), 64'(e_a[BW_ADDR+2:3]));
          chk("arsize", 64'(arsize), 64'(e_a[2:0]));
        end
        chk("arlen", 64'(arlen), 64'd0);
        chk("arburst", 64'(arburst), 64'd1);
        ar_pend = 0;
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else begin
          e_a = exp_aw.pop_front();
          chk("awaddr", 64'(awaddr), 64'(e_a[BW_ADDR+2:3]));
          chk("awsize", 64'(awsize), 64'(e_a[2:0]));
        end
        chk("awlen", 64'(awlen), 64'd0);
        chk("awburst", 64'(awburst), 64'd1);
        aw_pend = 0;
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          e_w = exp_w.pop_front();
          chk("wdata", 64'(wdata), 64'(e_w[BW_DATA+BW_STRB-1:BW_STRB]));
          chk("wstrb", 64'(wstrb), 64'(e_w[BW_STRB-1:0]));
        end
        chk("wlast", 64'(wlast), 64'd1);
        w_pend = 0;
      end

      // Pops act only on records already visible; a push this cycle is not.
      if (wr_info_pop && exp_wr.size() != 0) void'(exp_wr.pop_front());
      if (rd_info_pop && exp_rd.size() != 0) void'(exp_rd.pop_front());

      if (a_valid && a_ready) begin
        if (tgt_wr) begin
          exp_aw.push_back({a_address, a_size});
          exp_w.push_back({a_data, a_mask});
          exp_wr.push_back({3'd0, a_size, a_source, 1'b0});
          aw_pend = 1;
          w_pend  = 1;
        end else begin
          exp_ar.push_back({a_address, a_size});
          exp_rd.push_back({3'd1, a_size, a_source, a_opcode != 3'd4});
          ar_pend = 1;
        end
      end
    end
  end

  // Random slave readiness and consumer pops.
  bit rand_ready = 0, rand_pop = 0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      awready = ($urandom_range(0, 2) != 0);
      wready  = ($urandom_range(0, 2) != 0);
      arready = ($urandom_range(0, 2) != 0);
    end
    if (rand_pop) begin
      wr_info_pop = 1'($urandom_range(0, 1));
      rd_info_pop = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_directed();
    @(negedge clk);
    rand_ready = 0;
    rand_pop   = 0;
    step();
    awready = 1; wready = 1; arready = 1;
    wr_info_pop = 0; rd_info_pop = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                       input logic [3:0] src, input logic [3:0] mask, input logic [31:0] data);
    int n;
    bit done;
    n = 0;
    done = 0;
    a_valid = 1; a_opcode = op; a_address = addr; a_size = size;
    a_source = src; a_mask = mask; a_data = data;
    while (!done) begin
      @(negedge clk);
      if (a_ready) done = 1;
      else if (++n > 300) begin
        fail_now("a_ready_timeout");
        done = 1;
      end
    end
    step();
    a_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1; a_valid = 0; a_opcode = 0; a_size = 0; a_source = 0; a_address = 0;
    a_mask = 0; a_data = 0; awready = 0; wready = 0; arready = 0;
    wr_info_pop = 0; rd_info_pop = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_wr_info_valid", 64'(wr_info_valid), 64'd0);
    chk("rst_rd_info_valid", 64'(rd_info_valid), 64'd0);
    step();
    rst = 0;
    go_directed();

    // Get 0x100, size 2, source 3.
    issue(3'd4, 32'h100, 3'd2, 4'd3, 4'hf, 32'h0);
    repeat (2) step();
    chk("get_rd_info", 64'(rd_info), 64'({3'd1, 3'd2, 4'd3, 1'b0}));
    rd_info_pop = 1; step(); rd_info_pop = 0;

    // PutPartial with AW held off for 3 cycles, W ready at once.
    awready = 0;
    issue(3'd1, 32'h200, 3'd2, 4'd5, 4'b0101, 32'hAABBCCDD);
    repeat (3) step();
    awready = 1;
    repeat (3) step();
    chk("putpartial_wr_info", 64'(wr_info), 64'({3'd0, 3'd2, 4'd5, 1'b0}));
    wr_info_pop = 1; step(); wr_info_pop = 0;

    // Opcode 2 (arithmetic) is issued as a read and marked denied.
    issue(3'd2, 32'h340, 3'd1, 4'd9, 4'h3, 32'h0);
    repeat (2) step();
    chk("arith_rd_info", 64'(rd_info), 64'({3'd1, 3'd1, 4'd9, 1'b1}));
    rd_info_pop = 1; step(); rd_info_pop = 0;

    // Fill the write-record FIFO, then show the 5th Put is held off.
    for (int i = 0; i < MAXO; i++) issue(3'd0, 32'h1000 + 32'(i * 4), 3'd2, 4'(i), 4'hf, 32'(i));
    repeat (3) step();
    a_valid = 1; a_opcode = 3'd0; a_address = 32'h2000; a_source = 4'd7;
    repeat (3) begin
      @(negedge clk);
      chk("a_ready_full", 64'(a_ready), 64'd0);
    end
    step();
    wr_info_pop = 1;          // 4 -> 3
    step();                   // a_ready now high: push and pop together
    step();
    a_valid = 0; wr_info_pop = 0;
    repeat (3) step();
    issue(3'd0, 32'h3000, 3'd2, 4'd8, 4'hf, 32'h55);   // back to 4
    repeat (3) step();
    a_valid = 1; a_opcode = 3'd1;
    @(negedge clk);
    chk("a_ready_full_again", 64'(a_ready), 64'd0);
    step();
    a_valid = 0;
    wr_info_pop = 1;
    repeat (MAXO + 2) step();   // includes pops on an empty FIFO
    wr_info_pop = 0;
    step();

    // Reset in the middle of a write.
    awready = 0; wready = 0;
    issue(3'd0, 32'h4000, 3'd2, 4'd1, 4'hf, 32'h1234);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_awvalid", 64'(awvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(wvalid), 64'd0);
    chk("mid_rst_wr_info_valid", 64'(wr_info_valid), 64'd0);
    chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_wr.delete(); exp_rd.delete();
    ar_pend = 0; aw_pend = 0; w_pend = 0;
    awready = 1; wready = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_a_ready", 64'(a_ready), 64'd1);
    step();

    // Randomized traffic.
    @(negedge clk);
    rand_ready = 1;
    rand_pop   = 1;
    step();
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [2:0] op;
      r = $urandom_range(0, 9);
      if (r < 4) op = 3'd0;
      else if (r < 6) op = 3'd1;
      else if (r < 8) op = 3'd4;
      else op = 3'($urandom_range(0, 7));
      issue(op, $urandom, 3'($urandom_range(0, 2)), 4'($urandom), 4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) step();
    end

    // Drain everything still in flight.
    go_directed();
    wr_info_pop = 1; rd_info_pop = 1;
    repeat (20) step();
    wr_info_pop = 0; rd_info_pop = 0;
    step();
    chk("drain_ar", 64'(exp_ar.size()), 64'd0);
    chk("drain_aw", 64'(exp_aw.size()), 64'd0);
    chk("drain_w", 64'(exp_w.size()), 64'd0);
    chk("drain_wr_info", 64'(exp_wr.size()), 64'd0);
    chk("drain_rd_info", 64'(exp_rd.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
